// File: rtl/fft_agu.sv
// rtl/fft_agu.sv - address-generation and control FSM for an in-place radix-2 DIT FFT
module fft_agu #(
  parameter int M    = 9,
  parameter int PIPE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [M-1:0]         radr,
  output logic                 rphase,
  output logic [M-2:0]         twiddle_adr,
  output logic                 we,
  output logic [M-1:0]         wadr,
  output logic                 wphase,
  output logic [$clog2(M)-1:0] stage,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = $clog2(M);
  localparam int FW = $clog2(PIPE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  // cnt = 2*j + phase: butterfly index in the upper bits, A/B operand in bit 0
  logic [M-1:0]          cnt;
  logic [FW-1:0]         fcnt;
  logic                  last_read;
  logic                  flush_end;
  logic                  last_stage;
  logic [2*M-1:0]        rot;
  logic [M-2:0]          tw_mask;

  // Write-side delay line: valid, address and phase of every issued read
  logic [PIPE-1:0]         pv;
  logic [PIPE-1:0]         pp;
  logic [PIPE-1:0][M-1:0]  pa;

  assign last_read  = (cnt == {M{1'b1}});
  assign flush_end  = (fcnt == FW'(PIPE - 1));
  assign last_stage = (stage == SW'(M - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: RUN issues N reads, FLUSH drains PIPE cycles, DONE pulses once
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_read) state_nx = S_FLUSH;
      S_FLUSH: if (flush_end) state_nx = last_stage ? S_DONE : S_RUN;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Butterfly counter, flush counter and stage index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      fcnt  <= '0;
      stage <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= '0;
            stage <= '0;
          end
        end
        S_RUN: begin
          fcnt <= '0;
          // cnt parks on the last address so radr holds through FLUSH/DONE
          if (!last_read) cnt <= cnt + M'(1);
        end
        S_FLUSH: begin
          if (flush_end) begin
            if (!last_stage) begin
              cnt   <= '0;
              stage <= stage + SW'(1);
            end
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        S_DONE: begin
          cnt   <= '0;
          stage <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read address is the butterfly index rotated left by the stage number within M bits
  always_comb begin
    rot         = {cnt, cnt} << stage;
    radr        = rot[2*M-1:M];
    rphase      = cnt[0];
    tw_mask     = {(M-1){1'b1}} << (SW'(M - 1) - stage);
    twiddle_adr = cnt[M-1:1] & tw_mask;
  end

  // Delay every read by PIPE cycles to form the matching write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      pp <= '0;
      pa <= '0;
    end else begin
      pv <= {pv[PIPE-2:0], (state == S_RUN)};
      pp <= {pp[PIPE-2:0], rphase};
      pa <= {pa[PIPE-2:0], radr};
    end
  end

  assign we     = pv[PIPE-1];
  assign wphase = pp[PIPE-1];
  assign wadr   = pa[PIPE-1];
  assign busy   = (state == S_RUN) || (state == S_FLUSH);
  assign done   = (state == S_DONE);

endmodule
